// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: opcodes, R-type functs,
// ALU operation codes, operand selects and the decoded control bundle.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned IMM_W   = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL   = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL   = 6'h02;
    localparam logic [OP_W-1:0] FN_SLLV  = 6'h04;
    localparam logic [OP_W-1:0] FN_SRLV  = 6'h06;
    localparam logic [OP_W-1:0] FN_BREAK = 6'h0D;
    localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
    localparam logic [OP_W-1:0] FN_AND   = 6'h24;
    localparam logic [OP_W-1:0] FN_OR    = 6'h25;
    localparam logic [OP_W-1:0] FN_NOR   = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_RS_RT    = 2'b00,
        SEL_RS_IMM   = 2'b01,
        SEL_RT_SHAMT = 2'b10,
        SEL_RT_RS    = 2'b11
    } op_sel_e;

    typedef struct packed {
        logic    reg_dst;
        logic    jump;
        logic    branch;
        logic    mem_to_reg;
        logic    mem_write;
        logic    reg_write;
        op_sel_e alu_src;
        alu_op_e alu_ctrl;
        logic    halt;
        logic    imm_signed;
    } ctrl_t;

    // 16-bit immediate widened to a 32-bit operand, signed or unsigned
    function automatic logic [INSTR_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                      input logic sgn);
        return sgn ? {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm}
                   : {{(INSTR_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: logic ops, add/sub, signed set-less-than and shifts.
module mips_alu
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_e          ctrl,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    logic [SHAMT_W-1:0] shamt;
    logic               lt;

    assign shamt = op2[SHAMT_W-1:0];
    assign lt    = $signed(op1) < $signed(op2);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = op1 & op2;
            ALU_OR:  result = op1 | op2;
            ALU_ADD: result = op1 + op2;
            ALU_SUB: result = op1 - op2;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLL: result = op1 << shamt;
            ALU_SRL: result = op1 >> shamt;
            ALU_NOR: result = ~(op1 | op2);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_exec_unit.sv
// Single-cycle MIPS decode + execute, with all control strobes and the ALU
// result registered for a one-cycle latency.
module mips_exec_unit
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [XLEN-1:0]     rs_data,
    input  logic [XLEN-1:0]     rt_data,
    output logic                reg_dst,
    output logic                jump,
    output logic                branch,
    output logic                mem_to_reg,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          alu_src,
    output logic [3:0]          alu_ctrl,
    output logic [XLEN-1:0]     result,
    output logic                zero,
    output logic                halt
);

    logic [OP_W-1:0]    opcode;
    logic [OP_W-1:0]    funct;
    logic [XLEN-1:0]    imm_c;
    logic [XLEN-1:0]    op1_c;
    logic [XLEN-1:0]    op2_c;
    logic [XLEN-1:0]    alu_result_c;
    logic               alu_zero_c;
    ctrl_t              ctrl_c;
    logic               unused_reg_idx;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // register indices are resolved by the register file, not here
    assign unused_reg_idx = ^instr[25:16];

    // Main decode: opcode to strobes, then funct refines R-type
    always_comb begin
        ctrl_c            = '0;
        ctrl_c.alu_src    = SEL_RS_RT;
        ctrl_c.alu_ctrl   = ALU_ADD;
        ctrl_c.imm_signed = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.halt      = (funct == FN_BREAK);
                case (funct)
                    FN_SUB:  ctrl_c.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl_c.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl_c.alu_ctrl = ALU_OR;
                    FN_NOR:  ctrl_c.alu_ctrl = ALU_NOR;
                    FN_SLT:  ctrl_c.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        ctrl_c.alu_ctrl = ALU_SLL;
                        ctrl_c.alu_src  = SEL_RT_SHAMT;
                    end
                    FN_SRL: begin
                        ctrl_c.alu_ctrl = ALU_SRL;
                        ctrl_c.alu_src  = SEL_RT_SHAMT;
                    end
                    FN_SLLV: begin
                        ctrl_c.alu_ctrl = ALU_SLL;
                        ctrl_c.alu_src  = SEL_RT_RS;
                    end
                    FN_SRLV: begin
                        ctrl_c.alu_ctrl = ALU_SRL;
                        ctrl_c.alu_src  = SEL_RT_RS;
                    end
                    default: ctrl_c.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_ADDI: begin
                ctrl_c.alu_src   = SEL_RS_IMM;
                ctrl_c.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl_c.alu_src   = SEL_RS_IMM;
                ctrl_c.alu_ctrl  = ALU_SLT;
                ctrl_c.reg_write = 1'b1;
            end
            OP_ANDI: begin
                ctrl_c.alu_src    = SEL_RS_IMM;
                ctrl_c.alu_ctrl   = ALU_AND;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.imm_signed = 1'b0;
            end
            OP_ORI: begin
                ctrl_c.alu_src    = SEL_RS_IMM;
                ctrl_c.alu_ctrl   = ALU_OR;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.imm_signed = 1'b0;
            end
            OP_LW: begin
                ctrl_c.alu_src    = SEL_RS_IMM;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl_c.alu_src   = SEL_RS_IMM;
                ctrl_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_c.branch   = 1'b1;
                ctrl_c.alu_ctrl = ALU_SUB;
            end
            OP_J:    ctrl_c.jump = 1'b1;
            default: ctrl_c.alu_src = SEL_RS_RT;
        endcase
    end

    assign imm_c = XLEN'(extend_imm(instr[IMM_W-1:0], ctrl_c.imm_signed));

    // Operand select; shift forms put rt in op1 so the ALU always shifts op1
    always_comb begin
        op1_c = rs_data;
        op2_c = rt_data;
        case (ctrl_c.alu_src)
            SEL_RS_RT: begin
                op1_c = rs_data;
                op2_c = rt_data;
            end
            SEL_RS_IMM: begin
                op1_c = rs_data;
                op2_c = imm_c;
            end
            SEL_RT_SHAMT: begin
                op1_c = rt_data;
                op2_c = XLEN'(instr[10:6]);
            end
            SEL_RT_RS: begin
                op1_c = rt_data;
                op2_c = rs_data;
            end
            default: begin
                op1_c = rs_data;
                op2_c = rt_data;
            end
        endcase
    end

    mips_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .ctrl  (ctrl_c.alu_ctrl),
        .op1   (op1_c),
        .op2   (op2_c),
        .result(alu_result_c),
        .zero  (alu_zero_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_dst    <= 1'b0;
            jump       <= 1'b0;
            branch     <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            alu_src    <= 2'b00;
            alu_ctrl   <= 4'b0000;
            result     <= '0;
            zero       <= 1'b0;
            halt       <= 1'b0;
        end else begin
            reg_dst    <= ctrl_c.reg_dst;
            jump       <= ctrl_c.jump;
            branch     <= ctrl_c.branch;
            mem_to_reg <= ctrl_c.mem_to_reg;
            mem_write  <= ctrl_c.mem_write;
            reg_write  <= ctrl_c.reg_write;
            alu_src    <= ctrl_c.alu_src;
            alu_ctrl   <= ctrl_c.alu_ctrl;
            result     <= alu_result_c;
            zero       <= alu_zero_c;
            halt       <= ctrl_c.halt;
        end
    end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed literal cases plus
// randomized instructions checked every cycle against a behavioural model.
module tb_mips_exec_unit;

    typedef struct packed {
        logic        reg_dst;
        logic        jump;
        logic        branch;
        logic        mem_to_reg;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  alu_src;
        logic [3:0]  alu_ctrl;
        logic [31:0] result;
        logic        zero;
        logic        halt;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_dst, jump, branch, mem_to_reg, mem_write, reg_write;
    logic [1:0]  alu_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic        halt;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    exp_t exp_q  = '0;

    logic [5:0] op_pool [10] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A,
                                 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fn_pool [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                                 6'h00, 6'h02, 6'h04, 6'h06, 6'h0D, 6'h3E};

    mips_exec_unit #(.XLEN(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .reg_dst   (reg_dst),
        .jump      (jump),
        .branch    (branch),
        .mem_to_reg(mem_to_reg),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .alu_ctrl  (alu_ctrl),
        .result    (result),
        .zero      (zero),
        .halt      (halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // What the instruction word must produce, straight from the ISA rules
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] simm;
        logic [31:0] zimm;
        op   = i[31:26];
        fn   = i[5:0];
        sh   = i[10:6];
        simm = {{16{i[15]}}, i[15:0]};
        zimm = {16'h0000, i[15:0]};
        e = '0;
        e.alu_ctrl = 4'b0010;
        e.result   = a + b;
        case (op)
            6'h00: begin
                e.reg_dst   = 1'b1;
                e.reg_write = 1'b1;
                e.halt      = (fn == 6'h0D);
                case (fn)
                    6'h22: begin e.alu_ctrl = 4'b0110; e.result = a - b; end
                    6'h24: begin e.alu_ctrl = 4'b0000; e.result = a & b; end
                    6'h25: begin e.alu_ctrl = 4'b0001; e.result = a | b; end
                    6'h27: begin e.alu_ctrl = 4'b1100; e.result = ~(a | b); end
                    6'h2A: begin
                        e.alu_ctrl = 4'b0111;
                        e.result   = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    end
                    6'h00: begin e.alu_ctrl = 4'b1000; e.alu_src = 2'b10; e.result = b << sh; end
                    6'h02: begin e.alu_ctrl = 4'b1001; e.alu_src = 2'b10; e.result = b >> sh; end
                    6'h04: begin e.alu_ctrl = 4'b1000; e.alu_src = 2'b11; e.result = b << a[4:0]; end
                    6'h06: begin e.alu_ctrl = 4'b1001; e.alu_src = 2'b11; e.result = b >> a[4:0]; end
                    default: e.result = a + b;
                endcase
            end
            6'h08: begin e.alu_src = 2'b01; e.reg_write = 1'b1; e.result = a + simm; end
            6'h0A: begin
                e.alu_src = 2'b01; e.reg_write = 1'b1; e.alu_ctrl = 4'b0111;
                e.result  = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
            end
            6'h0C: begin e.alu_src = 2'b01; e.reg_write = 1'b1; e.alu_ctrl = 4'b0000; e.result = a & zimm; end
            6'h0D: begin e.alu_src = 2'b01; e.reg_write = 1'b1; e.alu_ctrl = 4'b0001; e.result = a | zimm; end
            6'h23: begin e.alu_src = 2'b01; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.result = a + simm; end
            6'h2B: begin e.alu_src = 2'b01; e.mem_write = 1'b1; e.result = a + simm; end
            6'h04: begin e.branch = 1'b1; e.alu_ctrl = 4'b0110; e.result = a - b; end
            6'h02: e.jump = 1'b1;
            default: e.result = a + b;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t d;
        d.reg_dst = reg_dst; d.jump = jump; d.branch = branch;
        d.mem_to_reg = mem_to_reg; d.mem_write = mem_write; d.reg_write = reg_write;
        d.alu_src = alu_src; d.alu_ctrl = alu_ctrl; d.result = result;
        d.zero = zero; d.halt = halt;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        exp_t d;
        d = dut_out();
        chk({tag, ".strobes"}, 32'({d.reg_dst, d.jump, d.branch, d.mem_to_reg, d.mem_write, d.reg_write}),
            32'({e.reg_dst, e.jump, e.branch, e.mem_to_reg, e.mem_write, e.reg_write}));
        chk({tag, ".alu_src"},  32'(d.alu_src),  32'(e.alu_src));
        chk({tag, ".alu_ctrl"}, 32'(d.alu_ctrl), 32'(e.alu_ctrl));
        chk({tag, ".result"},   d.result,        e.result);
        chk({tag, ".zero"},     32'(d.zero),     32'(e.zero));
        chk({tag, ".halt"},     32'(d.halt),     32'(e.halt));
    endtask

    // Expected register contents: reset clears, otherwise each edge captures model()
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) exp_q <= '0;
        else          exp_q <= model(instr, rs_data, rt_data);
    end

    always @(negedge clock) begin
        if (chk_en) chk_all("cycle", exp_q);
    end

    task automatic put(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #2;
        instr = i; rs_data = a; rt_data = b;
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic mid_reset();
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'(dut_out()), 32'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ri, ra, rb;
        reset_n = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        #1;
        chk("reset_state", 32'(dut_out()), 32'd0);
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;

        put(rtype(5'd0, 6'h20), 32'd7, 32'd5); settle();
        chk("add.result", result, 32'd12);
        chk("add.alu_ctrl", 32'(alu_ctrl), 32'h2);
        chk("add.dst_write", 32'({reg_dst, reg_write}), 32'h3);

        put(rtype(5'd0, 6'h22), 32'd3, 32'd5); settle();
        chk("sub.result", result, 32'hFFFF_FFFE);
        chk("sub.zero", 32'(zero), 32'd0);
        put(rtype(5'd0, 6'h2A), 32'd3, 32'd5); settle();
        chk("slt.result", result, 32'd1);

        put(itype(6'h08, 16'hFFFF), 32'd1, 32'd0); settle();
        chk("addi.result", result, 32'd0);
        chk("addi.zero", 32'(zero), 32'd1);
        put(itype(6'h0D, 16'hFFFF), 32'd0, 32'd0); settle();
        chk("ori.result", result, 32'h0000_FFFF);

        put(rtype(5'd4, 6'h00), 32'd0, 32'd1); settle();
        chk("sll.result", result, 32'h10);
        chk("sll.alu_src", 32'(alu_src), 32'h2);
        put(rtype(5'd0, 6'h06), 32'd31, 32'h8000_0000); settle();
        chk("srlv.result", result, 32'd1);
        chk("srlv.alu_src", 32'(alu_src), 32'h3);

        put(itype(6'h04, 16'h0010), 32'd9, 32'd9); settle();
        chk("beq.branch_zero", 32'({branch, zero}), 32'h3);
        put(itype(6'h23, 16'h0004), 32'h100, 32'd0); settle();
        chk("lw.mem_to_reg", 32'(mem_to_reg), 32'd1);
        put(itype(6'h2B, 16'h0004), 32'h100, 32'd0); settle();
        chk("sw.write_pair", 32'({mem_write, reg_write}), 32'h2);
        put({6'h02, 26'h123}, 32'd0, 32'd0); settle();
        chk("j.jump", 32'(jump), 32'd1);
        put({6'h3F, 26'h3FF_FFFF}, 32'd4, 32'd4); settle();
        chk("nop.strobes", 32'({reg_dst, jump, branch, mem_to_reg, mem_write, reg_write}), 32'd0);

        put(rtype(5'd0, 6'h0D), 32'd1, 32'd2); settle();
        chk("halt", 32'(halt), 32'd1);
        mid_reset();

        for (int n = 0; n < 1500; n++) begin
            ri = $urandom;
            ri[31:26] = op_pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) ri[31:26] = 6'($urandom);
            if (ri[31:26] == 6'h00) ri[5:0] = fn_pool[$urandom_range(0, 11)];
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = ra; end
                1: begin ra = $urandom_range(0, 40); rb = $urandom_range(0, 40); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            put(ri, ra, rb);
            if ($urandom_range(0, 199) == 0) mid_reset();
        end

        settle();
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_exec_unit.md
MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 instr  input  32  current instruction word (MIPS I encoding).
REQ-005 rs_data  input  32  register-file read port 1 (instr[25:21]).
REQ-006 rt_data  input  32  register-file read port 2 (instr[20:16]).
REQ-007 reg_dst, jump, branch, mem_to_reg, mem_write, reg_write  output  1 each  registered control strobes.
REQ-008 alu_src  output  2  registered operand select: 00 rs/rt, 01 rs/imm, 10 rt/shamt, 11 rt/rs.
REQ-009 alu_ctrl  output  4  registered ALU operation code.
REQ-010 result  output  32  registered ALU result.
REQ-011 zero  output  1  registered, high when result equals 0.
REQ-012 halt  output  1  registered, high for the break/halt instruction.

Function
REQ-013 Decode, operand select and ALU evaluation are combinational; all outputs are registered, giving 1-cycle latency from instr/rs_data/rt_data to outputs.
REQ-014 Opcode decode (op = instr[31:26]):
- 0x00 R-type: reg_dst=1, reg_write=1.
- 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori: alu_src=01, reg_write=1.
- 0x23 lw: alu_src=01, mem_to_reg=1, reg_write=1.
- 0x2B sw: alu_src=01, mem_write=1.
- 0x04 beq: branch=1.
- 0x02 j: jump=1.
- Any other opcode: all strobes 0, alu_src=00 (NOP).
REQ-015 R-type funct (instr[5:0]): 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl (both alu_src=10), 0x04 sllv, 0x06 srlv (both alu_src=11); unknown funct maps to add.
REQ-016 alu_ctrl encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SLL=1000, SRL=1001, NOR=1100.
REQ-017 Mapping: addi/lw/sw use ADD; beq uses SUB; slti uses SLT; andi uses AND; ori uses OR; j uses ADD.
REQ-018 Immediate: addi/slti/lw/sw/beq sign-extend instr[15:0]; andi/ori zero-extend it.
REQ-019 Operands: sel 00 op1=rs, op2=rt; sel 01 op1=rs, op2=imm; sel 10 op1=rt, op2=zero-extended instr[10:6]; sel 11 op1=rt, op2=rs.
REQ-020 Arithmetic is modulo 2^32; overflow is ignored and raises no trap.
REQ-021 SLT is a signed compare and returns 1 or 0.
REQ-022 Shift amount is op2[4:0]; SRL is a logical shift that fills with zeros.
REQ-023 zero is computed from the same-cycle result, so beq with rs==rt yields branch=1 and zero=1 together.
REQ-024 halt = (op==0x00 and funct==0x0D); all other outputs still follow normal decode for that word.

Reset
REQ-025 While reset_n is low, every output is 0 immediately, without waiting for a clock edge.
REQ-026 The first rising edge with reset_n high captures the current inputs.
REQ-027 Reset asserted mid-stream discards the pending result.

Structure
REQ-028 A shared package mips_pkg holds the opcode, funct and alu_ctrl encodings as localparams/enums.
REQ-029 The ALU is the one natural sub-module, named mips_alu: purely combinational, with ports ctrl, op1, op2, result and zero.
REQ-030 The decode logic stays in the top-level module.

Verification
REQ-031 add: rs=7, rt=5 -> next cycle result=12, alu_ctrl=0010, reg_dst=1, reg_write=1.
REQ-032 sub: rs=3, rt=5 -> result=0xFFFFFFFE, zero=0; slt on the same operands -> result=1.
REQ-033 addi with imm=0xFFFF, rs=1 -> result=0, zero=1; ori with imm=0xFFFF, rs=0 -> result=0x0000FFFF.
REQ-034 sll: shamt=4, rt=0x1 -> result=0x10, alu_src=10; srlv: rs=31, rt=0x80000000 -> result=1, alu_src=11.
REQ-035 beq: rs=rt=9 -> branch=1, zero=1; lw -> mem_to_reg=1; sw -> mem_write=1 and reg_write=0; j -> jump=1; opcode 0x3F -> all strobes 0.
REQ-036 Drive funct 0x0D -> halt=1 next cycle; then assert reset_n=0 between edges -> all outputs 0 immediately.
